// File: rtl/boot_image_loader.sv
// Boot image loader: parses a SYNC/len/payload/CSUM byte frame into RAM words
// and holds the CPU in reset until the image has arrived and its checksum matches.
module boot_image_loader #(
    parameter int          RAM_ADDR_WIDTH = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic                      rx_ready,
    input  logic                      start,
    output logic                      ram_wen,
    output logic [RAM_ADDR_WIDTH-1:0] ram_waddr,
    output logic [31:0]               ram_wdata,
    output logic                      cpu_resetn,
    output logic                      done,
    output logic                      error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] CAP = 17'(1) << RAM_ADDR_WIDTH;

    state_t      state, state_nx;
    logic        accept;
    logic [7:0]  len_lo;
    logic [15:0] len_m1;
    logic [15:0] word_cnt;
    logic [1:0]  byte_idx;
    logic [23:0] shift;
    logic [7:0]  csum;
    logic [7:0]  csum_next;
    logic [16:0] len_full;
    logic        last_word;

    assign accept    = rx_valid & rx_ready;
    assign len_full  = {1'b0, rx_data, len_lo};
    assign csum_next = csum + rx_data;
    assign last_word = (byte_idx == 2'd3) && (word_cnt == len_m1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (accept && rx_data == SYNC_BYTE) state_nx = S_LEN_LO;
            S_LEN_LO: if (accept) state_nx = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if (len_full > CAP)         state_nx = S_ERROR;
                    else if (len_full == 17'd0) state_nx = S_CSUM;
                    else                        state_nx = S_DATA;
                end
            end
            S_DATA:   if (accept && last_word) state_nx = S_CSUM;
            S_CSUM: begin
                if (accept) state_nx = (csum_next == 8'd0) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: if (start) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Status flags and rx_ready follow the next state so they change with the accepting edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ready   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_resetn <= 1'b0;
            ram_wen    <= 1'b0;
            ram_waddr  <= '0;
            ram_wdata  <= '0;
            len_lo     <= '0;
            len_m1     <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
            shift      <= '0;
            csum       <= '0;
        end else begin
            rx_ready   <= state_nx inside {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};
            done       <= state_nx == S_DONE;
            error      <= state_nx == S_ERROR;
            cpu_resetn <= state_nx == S_DONE;
            ram_wen    <= 1'b0;
            // Saturate at the top word so a full-capacity image never wraps.
            if (ram_wen && ram_waddr != '1) ram_waddr <= ram_waddr + 1'b1;
            unique case (state)
                S_IDLE: begin
                    csum     <= '0;
                    word_cnt <= '0;
                    byte_idx <= '0;
                end
                S_LEN_LO: if (accept) len_lo <= rx_data;
                S_LEN_HI: if (accept) len_m1 <= len_full[15:0] - 16'd1;
                S_DATA: begin
                    if (accept) begin
                        csum     <= csum_next;
                        byte_idx <= byte_idx + 2'd1;
                        shift    <= {rx_data, shift[23:8]};
                        if (byte_idx == 2'd3) begin
                            ram_wen   <= 1'b1;
                            ram_wdata <= {rx_data, shift};
                            word_cnt  <= word_cnt + 16'd1;
                        end
                    end
                end
                S_CSUM: ;
                S_DONE, S_ERROR: begin
                    if (start) begin
                        ram_waddr <= '0;
                        csum      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_image_loader.sv
// Randomized bench for boot_image_loader against a frame-level reference model.
module tb_boot_image_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        start = 1'b0;
    logic        rx_ready;
    logic        ram_wen;
    logic [7:0]  ram_waddr;
    logic [31:0] ram_wdata;
    logic        cpu_resetn;
    logic        done;
    logic        error;

    int checks = 0;
    int failures = 0;

    logic [39:0] wq[$];
    logic [39:0] eq[$];

    boot_image_loader #(.RAM_ADDR_WIDTH(8), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .start(start),
        .ram_wen(ram_wen),
        .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata),
        .cpu_resetn(cpu_resetn),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ram_wen) wq.push_back({ram_waddr, ram_wdata});

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame-level model: status 0=none, 1=done, 2=error.
    task automatic model(input logic [7:0] q[$], output int st, output int wend);
        int i = 0;
        int n;
        int sum = 0;
        int word;
        st = 0;
        wend = 0;
        eq.delete();
        while (i < q.size() && q[i] != 8'hA5) i++;
        if (i + 2 >= q.size()) return;
        n = int'(q[i+1]) + 256 * int'(q[i+2]);
        i += 3;
        if (n > 256) begin
            st = 2;
            return;
        end
        for (int w = 0; w < n; w++) begin
            word = 0;
            for (int k = 0; k < 4; k++) begin
                word += int'(q[i]) << (8 * k);
                sum += int'(q[i]);
                i++;
            end
            eq.push_back({8'(w), 32'(word)});
        end
        st = ((sum + int'(q[i])) % 256 == 0) ? 1 : 2;
        wend = (n == 256) ? 255 : n;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data = b;
        while (!rx_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rx_ready) chk("rdy_timeout", 0, 1);
        else begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] q[$], input int maxgap);
        int st;
        int wend;
        model(q, st, wend);
        wq.delete();
        foreach (q[i]) begin
            repeat ($urandom_range(0, maxgap)) begin
                @(posedge clk); #1;
            end
            send_byte(q[i]);
        end
        chk({tag, "_done"}, int'(done), int'(st == 1));
        chk({tag, "_error"}, int'(error), int'(st == 2));
        chk({tag, "_cpurst"}, int'(cpu_resetn), int'(st == 1));
        chk({tag, "_rdy"}, int'(rx_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_nwr"}, wq.size(), eq.size());
        for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
            chk({tag, "_addr"}, int'(wq[i][39:32]), int'(eq[i][39:32]));
            chk({tag, "_data"}, int'(wq[i][31:0]), int'(eq[i][31:0]));
        end
        chk({tag, "_waddr"}, int'(ram_waddr), wend);
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_st_done"}, int'(done), 0);
        chk({tag, "_st_err"}, int'(error), 0);
        chk({tag, "_st_cpu"}, int'(cpu_resetn), 0);
        chk({tag, "_st_rdy"}, int'(rx_ready), 1);
        chk({tag, "_st_waddr"}, int'(ram_waddr), 0);
    endtask

    initial begin
        logic [7:0] t1[$];
        logic [7:0] q[$];
        int n;
        int sum;
        t1 = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h93,
               8'h6F, 8'h00, 8'h00, 8'h00, 8'hEB};

        #1;
        chk("rst_rdy", int'(rx_ready), 0);
        chk("rst_wen", int'(ram_wen), 0);
        chk("rst_waddr", int'(ram_waddr), 0);
        chk("rst_wdata", int'(ram_wdata), 0);
        chk("rst_cpu", int'(cpu_resetn), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(error), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rel_rdy0", int'(rx_ready), 0);
        @(posedge clk); #1;
        chk("rel_rdy1", int'(rx_ready), 1);

        run_frame("t1", t1, 0);
        chk("t1_w0", int'(wq.size() > 0 ? wq[0][31:0] : 32'h0), 32'h93000013);
        pulse_start("t1");

        q = t1;
        q[11] = 8'hEC;
        run_frame("t2", q, 0);
        pulse_start("t2");

        q = '{8'hA5, 8'h01, 8'h01};
        run_frame("t3", q, 0);
        pulse_start("t3");

        q = '{8'h00, 8'hFF, 8'h5A};
        foreach (t1[i]) q.push_back(t1[i]);
        run_frame("t4", q, 5);
        pulse_start("t4");

        for (int i = 0; i < 9; i++) send_byte(t1[i]);
        reset = 1'b1;
        #1;
        chk("t5_rdy", int'(rx_ready), 0);
        chk("t5_wen", int'(ram_wen), 0);
        chk("t5_waddr", int'(ram_waddr), 0);
        chk("t5_cpu", int'(cpu_resetn), 0);
        chk("t5_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        run_frame("t5", t1, 0);
        pulse_start("t5");

        q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame("t6", q, 0);
        pulse_start("t6");

        q = '{8'hA5, 8'h00, 8'h01};
        sum = 0;
        for (int i = 0; i < 1024; i++) begin
            q.push_back(8'($urandom));
            sum += int'(q[q.size()-1]);
        end
        q.push_back(8'((256 - sum % 256) % 256));
        run_frame("full", q, 0);
        pulse_start("full");

        for (int r = 0; r < 8; r++) begin
            q.delete();
            repeat ($urandom_range(0, 2)) q.push_back(8'($urandom_range(0, 8'hA4)));
            n = $urandom_range(0, 6);
            q.push_back(8'hA5);
            q.push_back(8'(n));
            q.push_back(8'h00);
            sum = 0;
            for (int i = 0; i < 4 * n; i++) begin
                q.push_back(8'($urandom));
                sum += int'(q[q.size()-1]);
            end
            sum = (256 - sum % 256) % 256;
            if ($urandom_range(0, 1) == 1) sum = (sum + 1) % 256;
            q.push_back(8'(sum));
            run_frame("rnd", q, $urandom_range(0, 3));
            pulse_start("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
